// File: rtl/axis_demux_pkg.sv
// Shared types and helpers for the queued AXI4-Stream demultiplexer.
// Holds select-width helper, drop-counter width and queue-level type.
package axis_demux_pkg;

    localparam int DROP_CNT_W = 32;
    localparam int LEVEL_W_MAX = 16;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;
    typedef logic [LEVEL_W_MAX-1:0] q_level_t;

    // Width able to encode 0..n, so one out-of-range index always exists.
    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_demux_if.sv
// Handshake interfaces used by the demux: a plain ready/valid channel
// and an AXI4-Stream channel (tdata/tkeep/tlast/tvalid/tready).
interface ready_valid_i #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport m (output data, valid, input ready);
    modport s (input data, valid, output ready);
endinterface

interface AXI4S #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport m (output tdata, tkeep, tlast, tvalid, input tready);
    modport s (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice with a registered upstream ready.
// Ports: up_* (valid/ready/data in), dn_* (valid/ready/data out).
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         up_fire;

    // Ready depends only on the spare register, never on dn_ready.
    assign up_ready = !skid_valid;
    assign up_fire  = up_valid && up_ready;
    assign dn_valid = main_valid;
    assign dn_data  = main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (!main_valid || dn_ready) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= up_fire;
                if (up_fire) main_data <= up_data;
            end
        end else if (up_fire) begin
            // Output stalled: park the beat in the spare slot.
            skid_data  <= up_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_demux_queued.sv
// Packet demux: queued destination indices steer whole packets from
// `in` to out[i] through per-output skid slices. Ports: clk, rst,
// select (index channel), in, out[], dropped_packets, select_level, busy.
module axis_demux_queued
    import axis_demux_pkg::*;
#(
    parameter int NUM_STREAMS  = 4,
    parameter int SELECT_DEPTH = 4,
    parameter int DROP_INVALID = 1,
    parameter int DATA_W       = 8,
    parameter int SEL_W        = sel_w(NUM_STREAMS),
    localparam int LVL_W       = $clog2(SELECT_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    ready_valid_i.s               select,
    AXI4S.s                       in,
    AXI4S.m                       out [NUM_STREAMS],
    output logic [DROP_CNT_W-1:0] dropped_packets,
    output logic [LVL_W-1:0]      select_level,
    output logic                  busy
);

    localparam int AW = $clog2(SELECT_DEPTH);
    localparam int KW = DATA_W / 8;
    localparam int PW = DATA_W + KW + 1;

    logic [SEL_W-1:0] q_mem [SELECT_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             q_empty;
    logic             q_full;
    logic             push;
    logic             pop;

    logic [SEL_W-1:0] head;
    logic [SEL_W-1:0] dest;
    logic             invalid;
    logic             drop;
    logic             dest_ready;
    logic             in_fire;

    logic [NUM_STREAMS-1:0] sk_up_valid;
    logic [NUM_STREAMS-1:0] sk_up_ready;
    logic [NUM_STREAMS-1:0] sk_dn_valid;
    logic [NUM_STREAMS-1:0] sk_dn_ready;
    logic [PW-1:0]          sk_dn_data [NUM_STREAMS];
    logic [PW-1:0]          payload;

    drop_cnt_t drop_cnt;

    // Select queue: extra pointer bit separates full from empty.
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign select.ready = !q_full && !rst;
    assign push         = select.valid && select.ready;
    assign select_level = LVL_W'(wr_ptr - rd_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr[AW-1:0]] <= select.data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Routing: head only moves on tlast, so the route is packet-stable.
    assign head    = q_mem[rd_ptr[AW-1:0]];
    assign invalid = (head >= SEL_W'(NUM_STREAMS));
    assign drop    = invalid && (DROP_INVALID != 0);
    assign dest    = invalid ? SEL_W'(NUM_STREAMS - 1) : head;

    always_comb begin
        dest_ready  = 1'b0;
        sk_up_valid = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (dest == SEL_W'(i)) begin
                dest_ready     = sk_up_ready[i];
                sk_up_valid[i] = in.tvalid && !q_empty && !drop && !rst;
            end
        end
    end

    assign in.tready = !rst && !q_empty && (drop || dest_ready);
    assign in_fire   = in.tvalid && in.tready;
    assign pop       = in_fire && in.tlast;
    assign payload   = {in.tdata, in.tkeep, in.tlast};

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (pop && drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign dropped_packets = drop_cnt;
    assign busy            = !q_empty || (|sk_dn_valid);

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_out
        axis_skid_buffer #(
            .W (PW)
        ) u_skid (
            .clk      (clk),
            .rst      (rst),
            .up_valid (sk_up_valid[g]),
            .up_ready (sk_up_ready[g]),
            .up_data  (payload),
            .dn_valid (sk_dn_valid[g]),
            .dn_ready (sk_dn_ready[g]),
            .dn_data  (sk_dn_data[g])
        );

        assign out[g].tvalid = sk_dn_valid[g];
        assign out[g].tdata  = sk_dn_data[g][PW-1 -: DATA_W];
        assign out[g].tkeep  = sk_dn_data[g][KW:1];
        assign out[g].tlast  = sk_dn_data[g][0];
        assign sk_dn_ready[g] = out[g].tready;
    end

endmodule

// File: tb/tb_axis_demux_queued.sv
// Directed bench for axis_demux_queued with a routing scoreboard.
// Two instances: DROP_INVALID=1 (dut_a) and DROP_INVALID=0 (dut_b).
module tb_axis_demux_queued;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       use_b;
    logic       s_valid;
    logic [2:0] s_data;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_last;
    logic [3:0] oready;

    logic [3:0] ovalid;
    logic [7:0] odata [4];
    logic [3:0] olast;
    logic       sel_ready;
    logic       in_ready;
    logic [2:0] level;
    logic [31:0] dropped;
    logic       busy;

    logic [31:0] drop_a, drop_b;
    logic [2:0]  level_a, level_b;
    logic        busy_a, busy_b;

    ready_valid_i #(.W(3)) sel_a ();
    ready_valid_i #(.W(3)) sel_b ();
    AXI4S #(.DATA_W(8)) in_a ();
    AXI4S #(.DATA_W(8)) in_b ();
    AXI4S #(.DATA_W(8)) out_a [4] ();
    AXI4S #(.DATA_W(8)) out_b [4] ();

    axis_demux_queued #(
        .NUM_STREAMS (4),
        .SELECT_DEPTH(4),
        .DROP_INVALID(1),
        .DATA_W      (8)
    ) dut_a (
        .clk            (clk),
        .rst            (rst),
        .select         (sel_a),
        .in             (in_a),
        .out            (out_a),
        .dropped_packets(drop_a),
        .select_level   (level_a),
        .busy           (busy_a)
    );

    axis_demux_queued #(
        .NUM_STREAMS (4),
        .SELECT_DEPTH(4),
        .DROP_INVALID(0),
        .DATA_W      (8)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .select         (sel_b),
        .in             (in_b),
        .out            (out_b),
        .dropped_packets(drop_b),
        .select_level   (level_b),
        .busy           (busy_b)
    );

    assign sel_a.valid = s_valid && !use_b;
    assign sel_b.valid = s_valid && use_b;
    assign sel_a.data  = s_data;
    assign sel_b.data  = s_data;
    assign in_a.tvalid = i_valid && !use_b;
    assign in_b.tvalid = i_valid && use_b;
    assign in_a.tdata  = i_data;
    assign in_b.tdata  = i_data;
    assign in_a.tkeep  = 1'b1;
    assign in_b.tkeep  = 1'b1;
    assign in_a.tlast  = i_last;
    assign in_b.tlast  = i_last;

    assign sel_ready = use_b ? sel_b.ready : sel_a.ready;
    assign in_ready  = use_b ? in_b.tready : in_a.tready;
    assign level     = use_b ? level_b : level_a;
    assign dropped   = use_b ? drop_b : drop_a;
    assign busy      = use_b ? busy_b : busy_a;

    for (genvar g = 0; g < 4; g++) begin : g_mux
        assign out_a[g].tready = oready[g];
        assign out_b[g].tready = oready[g];
        assign ovalid[g] = use_b ? out_b[g].tvalid : out_a[g].tvalid;
        assign odata[g]  = use_b ? out_b[g].tdata : out_a[g].tdata;
        assign olast[g]  = use_b ? out_b[g].tlast : out_a[g].tlast;
    end

    int passes = 0;
    int checks = 0;
    int cyc = 0;
    bit lat_chk = 0;

    beat_t src_q [$];
    beat_t exp_q [4][$];
    int    sel_src [$];
    int    sel_model [$];
    int    drop_model [2];
    logic  hold [4];
    logic [7:0] hold_d [4];
    logic  hold_l [4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        if (src_q.size() > 0) begin
            i_valid = 1'b1;
            i_data  = src_q[0].data;
            i_last  = src_q[0].last;
        end else begin
            i_valid = 1'b0;
            i_data  = 8'h00;
            i_last  = 1'b0;
        end
        if (sel_src.size() > 0) begin
            s_valid = 1'b1;
            s_data  = 3'(sel_src[0]);
        end else begin
            s_valid = 1'b0;
            s_data  = 3'd0;
        end
    endtask

    task automatic monitor();
        beat_t b;
        beat_t e;
        int d;
        if (rst) return;
        chk("level", 32'(level), 32'(sel_model.size()));
        chk("dropped", dropped, 32'(drop_model[use_b]));
        for (int i = 0; i < 4; i++) begin
            if (hold[i]) begin
                chk($sformatf("hold_v%0d", i), 32'(ovalid[i]), 1);
                chk($sformatf("hold_d%0d", i), {23'd0, odata[i], olast[i]},
                    {23'd0, hold_d[i], hold_l[i]});
            end
            if (ovalid[i] && oready[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("unexp_out%0d", i),
                        32'(exp_q[i].size()), 1);
                end else begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("data%0d", i), 32'(odata[i]), 32'(e.data));
                    chk($sformatf("last%0d", i), 32'(olast[i]), 32'(e.last));
                    if (lat_chk) chk("latency", 32'(cyc - e.cyc), 1);
                end
            end
            hold[i]   = ovalid[i] && !oready[i];
            hold_d[i] = odata[i];
            hold_l[i] = olast[i];
        end
        if (i_valid && in_ready) begin
            b = src_q.pop_front();
            b.cyc = cyc;
            if (sel_model.size() == 0) begin
                chk("route_q", 32'(sel_model.size()), 1);
            end else begin
                d = sel_model[0];
                if (d >= 4) d = use_b ? 3 : -1;
                if (d >= 0) exp_q[d].push_back(b);
                if (b.last) begin
                    void'(sel_model.pop_front());
                    if (d < 0) drop_model[use_b]++;
                end
            end
        end
        if (s_valid && sel_ready) sel_model.push_back(sel_src.pop_front());
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    function automatic int pending();
        int n = src_q.size() + sel_src.size();
        for (int i = 0; i < 4; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic run(input string tag, input int max, input int tog);
        int n = 0;
        while (pending() != 0 && n < max) begin
            if (tog >= 0) oready[tog] = ~oready[tog];
            tick();
            n++;
        end
        chk({"drain_", tag}, 32'(pending()), 0);
    endtask

    task automatic clear_model();
        src_q.delete();
        sel_src.delete();
        sel_model.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            hold[i] = 1'b0;
        end
        drop_model[0] = 0;
        drop_model[1] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sel_ready", 32'(sel_ready), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        drive();
        chk("rst_ovalid", 32'(ovalid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    task automatic add_pkt(input logic [7:0] base, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + 8'(k);
            b.last = (k == n - 1);
            b.cyc  = 0;
            src_q.push_back(b);
        end
    endtask

    initial begin
        use_b  = 1'b0;
        oready = 4'hF;
        rst    = 1'b1;
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Two packets to out[2] then out[0], checking 1-cycle latency.
        lat_chk = 1;
        sel_src.push_back(2);
        sel_src.push_back(0);
        add_pkt(8'hA1, 3);
        add_pkt(8'hB1, 1);
        drive();
        run("basic", 40, -1);
        lat_chk = 0;
        tick();
        chk("basic_level", 32'(level), 0);
        chk("basic_busy", 32'(busy), 0);

        // Fill the select queue with valid held high.
        sel_src = '{0, 1, 2, 3, 0};
        drive();
        repeat (6) tick();
        chk("full_level", 32'(level), 4);
        chk("full_ready", 32'(sel_ready), 0);
        chk("full_pending", 32'(sel_src.size()), 1);
        add_pkt(8'hC0, 1);
        drive();
        tick();
        chk("pop_ready", 32'(sel_ready), 1);
        chk("pop_level", 32'(level), 3);
        add_pkt(8'hC1, 1);
        add_pkt(8'hC2, 1);
        add_pkt(8'hC3, 1);
        add_pkt(8'hC4, 1);
        run("fill", 40, -1);

        // Out-of-range index dropped: 5 beats in 5 cycles.
        sel_src.push_back(4);
        drive();
        repeat (2) tick();
        add_pkt(8'hD0, 5);
        drive();
        repeat (5) tick();
        chk("drop_accept", 32'(src_q.size()), 0);
        chk("drop_count", dropped, 1);
        chk("drop_busy", 32'(busy), 0);

        // Same index on the DROP_INVALID=0 instance lands on out[3].
        use_b = 1'b1;
        sel_src.push_back(4);
        add_pkt(8'h50, 5);
        drive();
        run("route_last", 40, -1);
        tick();
        chk("b_dropped", dropped, 0);
        use_b = 1'b0;
        drive();

        // 16-beat packet with out[1] ready toggling every cycle.
        sel_src.push_back(1);
        add_pkt(8'h10, 16);
        drive();
        run("toggle", 80, 1);
        oready = 4'hF;
        tick();

        // Data with no select: never accepted.
        add_pkt(8'hE0, 4);
        drive();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("noq_ready", 32'(in_ready), 0);
        end
        sel_src.push_back(2);
        drive();
        repeat (3) tick();
        chk("mid_sent", 32'(src_q.size()), 2);
        do_reset();

        // out[0] stalled: pkt0 parks in skid[0], pkt1 still reaches out[1].
        oready = 4'b1110;
        sel_src.push_back(0);
        sel_src.push_back(1);
        add_pkt(8'h60, 2);
        add_pkt(8'h70, 3);
        drive();
        repeat (14) tick();
        chk("indep_src", 32'(src_q.size()), 0);
        chk("indep_out1", 32'(exp_q[1].size()), 0);
        chk("indep_out0", 32'(exp_q[0].size()), 2);
        chk("indep_v0", 32'(ovalid[0]), 1);
        oready = 4'hF;
        run("indep", 20, -1);
        tick();
        chk("end_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
